// File: rtl/alu_stage_pkg.sv
// Shared types for the ALU result stage: buffer states, jump condition codes
// and the flag portion of a buffered entry.
package alu_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  localparam logic [2:0] JC_ALWAYS = 3'd0;
  localparam logic [2:0] JC_C      = 3'd1;
  localparam logic [2:0] JC_Z      = 3'd2;
  localparam logic [2:0] JC_N      = 3'd3;
  localparam logic [2:0] JC_NC     = 3'd4;
  localparam logic [2:0] JC_NZ     = 3'd5;
  localparam logic [2:0] JC_NN     = 3'd6;
  localparam logic [2:0] JC_NEVER  = 3'd7;

  // The result field width is a module parameter, so the package carries the
  // flag part of an entry and the top wraps it with the result.
  typedef struct packed {
    logic c;
    logic z;
    logic n;
  } entry_flags_t;

endpackage

// File: rtl/alu_result_stage_jump_cond_eval.sv
// Combinational branch condition evaluation on the head entry's flags.
module jump_cond_eval
  import alu_stage_pkg::*;
(
  input  logic         valid,
  input  logic [2:0]   cond,
  input  entry_flags_t flags,
  output logic         taken
);

  always_comb begin
    taken = 1'b0;
    if (valid) begin
      case (cond)
        JC_ALWAYS: taken = 1'b1;
        JC_C:      taken = flags.c;
        JC_Z:      taken = flags.z;
        JC_N:      taken = flags.n;
        JC_NC:     taken = ~flags.c;
        JC_NZ:     taken = ~flags.z;
        JC_NN:     taken = ~flags.n;
        default:   taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer between the ALU and its consumer, with an architectural
// flags register. Define ALU_STAGE_JUMP_EVAL_EN to add jump condition evaluation.
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              carry,
  input  logic              zero,
  input  logic              negative,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              out_zero,
  output logic              out_negative,
  output logic              flag_c,
  output logic              flag_z,
  output logic              flag_n
`ifdef ALU_STAGE_JUMP_EVAL_EN
  ,
  input  logic [2:0]        jump_cond,
  output logic              jump_taken
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    entry_flags_t      flags;
  } entry_t;

  state_e       state_q, state_d;
  entry_t       head_q, head_d;
  entry_t       tail_q, tail_d;
  entry_flags_t arch_q, arch_d;
  logic         in_ready_q, in_ready_d;
  entry_t       in_entry;
  logic         push, pop;

  assign in_entry  = '{result: alu_result, flags: '{c: carry, z: zero, n: negative}};
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    arch_d  = arch_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_entry;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          state_d = TWO;
          tail_d  = in_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a pop can happen; the skid entry moves up.
        if (pop) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (pop) begin
      arch_d = head_q.flags;
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
      arch_q     <= '0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      arch_q     <= arch_d;
      head_q     <= head_d;
    end
  end

  // The skid slot is only read in TWO, so it needs no reset.
  always_ff @(posedge clk) begin
    tail_q <= tail_d;
  end

  assign in_ready     = in_ready_q;
  assign out_data     = head_q.result;
  assign out_carry    = head_q.flags.c;
  assign out_zero     = head_q.flags.z;
  assign out_negative = head_q.flags.n;
  assign flag_c       = arch_q.c;
  assign flag_z       = arch_q.z;
  assign flag_n       = arch_q.n;

`ifdef ALU_STAGE_JUMP_EVAL_EN
  jump_cond_eval u_jump_cond_eval (
    .valid (out_valid),
    .cond  (jump_cond),
    .flags (head_q.flags),
    .taken (jump_taken)
  );
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] alu_result = 8'h00;
  logic       carry = 1'b0, zero = 1'b0, negative = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_carry, out_zero, out_negative;
  logic       flag_c, flag_z, flag_n;
`ifdef ALU_STAGE_JUMP_EVAL_EN
  logic [2:0] jump_cond = 3'd0;
  logic       jump_taken;
`endif

  int checks = 0;
  int errors = 0;

  alu_result_stage #(.DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .carry        (carry),
    .zero         (zero),
    .negative     (negative),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_negative (out_negative),
    .flag_c       (flag_c),
    .flag_z       (flag_z),
    .flag_n       (flag_n)
`ifdef ALU_STAGE_JUMP_EVAL_EN
    ,
    .jump_cond    (jump_cond),
    .jump_taken   (jump_taken)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of entries, an upstream-ready bit and the flags register.
  typedef struct {
    logic [7:0] d;
    logic       c, z, n;
  } ent_t;

  ent_t q[$];
  logic ready_m = 1'b0;
  logic [2:0] flags_m = 3'b000;
  bit   live = 0;

  always @(posedge clk) begin
    bit   push_m, pop_m;
    ent_t e;
    if (reset) begin
      q.delete();
      ready_m = 1'b0;
      flags_m = 3'b000;
      live    = 1;
    end else begin
      push_m = in_valid && ready_m;
      pop_m  = (q.size() != 0) && out_ready;
      if (pop_m) begin
        flags_m = {q[0].c, q[0].z, q[0].n};
        void'(q.pop_front());
      end
      if (push_m) begin
        e.d = alu_result; e.c = carry; e.z = zero; e.n = negative;
        q.push_back(e);
      end
      ready_m = (q.size() < 2);
    end
  end

`ifdef ALU_STAGE_JUMP_EVAL_EN
  function automatic logic jump_model(input logic [2:0] jc, input ent_t h);
    case (jc)
      3'd0: return 1'b1;
      3'd1: return h.c;
      3'd2: return h.z;
      3'd3: return h.n;
      3'd4: return !h.c;
      3'd5: return !h.z;
      3'd6: return !h.n;
      default: return 1'b0;
    endcase
  endfunction
`endif

  logic       prev_hold = 1'b0;
  logic [10:0] prev_out = '0;

  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, ready_m);
      chk("arch_flags", {flag_c, flag_z, flag_n}, flags_m);
      if (q.size() != 0) begin
        chk("head", {out_data, out_carry, out_zero, out_negative},
            {q[0].d, q[0].c, q[0].z, q[0].n});
      end
`ifdef ALU_STAGE_JUMP_EVAL_EN
      chk("jump_taken", jump_taken, (q.size() != 0) ? jump_model(jump_cond, q[0]) : 1'b0);
`endif
      if (prev_hold) begin
        chk("stall_stable", {out_valid, out_data, out_carry, out_zero, out_negative},
            {1'b1, prev_out});
      end
      prev_hold = out_valid && !out_ready && !reset;
      prev_out  = {out_data, out_carry, out_zero, out_negative};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic z, input logic n);
    in_valid = v; alu_result = d; carry = c; zero = z; negative = n;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_flags", {flag_c, flag_z, flag_n}, 3'b000);
    chk("rst_out", {out_data, out_carry, out_zero, out_negative}, 11'h000);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", in_ready, 1'b1);

    // Single entry with immediate pop
    drive(1, 8'h3C, 1, 0, 0); out_ready = 1'b1;
    tick();
    drive(0, 8'h00, 0, 0, 0);
    chk("single_valid", out_valid, 1'b1);
    chk("single_data", out_data, 8'h3C);
    chk("single_flagc_pre", flag_c, 1'b0);
    tick();
    chk("single_flagc_post", flag_c, 1'b1);
    chk("single_empty", out_valid, 1'b0);

    // Fill with consumer stalled, then drain in order
    out_ready = 1'b0;
    drive(1, 8'h01, 0, 0, 0); tick();
    drive(1, 8'h02, 0, 0, 0); tick();
    chk("fill_not_ready", in_ready, 1'b0);
    drive(1, 8'h03, 0, 0, 0); tick();
    chk("fill_still_full", in_ready, 1'b0);
    chk("fill_head", out_data, 8'h01);
    out_ready = 1'b1; tick();
    chk("drain_0x02", out_data, 8'h02);
    chk("drain_ready", in_ready, 1'b1);
    tick();
    chk("drain_0x03", out_data, 8'h03);
    drive(0, 8'h00, 0, 0, 0); tick();
    chk("drain_empty", out_valid, 1'b0);

    // Simultaneous push and pop in ONE
    out_ready = 1'b0;
    drive(1, 8'h10, 0, 0, 0); tick();
    chk("pp_head", out_data, 8'h10);
    drive(1, 8'h20, 1, 0, 0); out_ready = 1'b1; tick();
    chk("pp_valid", out_valid, 1'b1);
    chk("pp_new_head", out_data, 8'h20);
    drive(0, 8'h00, 0, 0, 0); tick();
    chk("pp_flagc", flag_c, 1'b1);

    // Reset while full, with out_ready high during the reset edge
    out_ready = 1'b0;
    drive(1, 8'hAA, 0, 1, 1); tick();
    drive(1, 8'hBB, 0, 0, 0); tick();
    chk("full_before_rst", in_ready, 1'b0);
    drive(0, 8'h00, 0, 0, 0); reset = 1'b1; out_ready = 1'b1; tick();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_flags", {flag_c, flag_z, flag_n}, 3'b000);
    chk("mid_rst_data", out_data, 8'h00);
    reset = 1'b0; out_ready = 1'b0; tick();
    chk("mid_rst_ready", in_ready, 1'b1);

`ifdef ALU_STAGE_JUMP_EVAL_EN
    drive(1, 8'h55, 0, 1, 0); tick();
    drive(0, 8'h00, 0, 0, 0);
    jump_cond = 3'd2; #1;
    chk("jump_z", jump_taken, 1'b1);
    jump_cond = 3'd5; #1;
    chk("jump_nz", jump_taken, 1'b0);
    out_ready = 1'b1; tick();
    jump_cond = 3'd0; #1;
    chk("jump_invalid", jump_taken, 1'b0);
    out_ready = 1'b0;
`endif

    // Random traffic with random consumer stalls
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 2) == 0);
`ifdef ALU_STAGE_JUMP_EVAL_EN
      jump_cond = 3'($urandom);
`endif
      tick();
    end
    drive(0, 8'h00, 0, 0, 0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("final_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream ALU output is valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the stage can accept an entry this cycle.
REQ-006 The block SHALL have port alu_result, input, DATA_W bits: the ALU result.
REQ-007 The block SHALL have ports carry, zero and negative, input, 1 bit each: the ALU flags.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the head entry.
REQ-010 The block SHALL have port out_data, output, DATA_W bits: the head entry result.
REQ-011 The block SHALL have ports out_carry, out_zero and out_negative, output, 1 bit each: the head entry flags.
REQ-012 The block SHALL have ports flag_c, flag_z and flag_n, output, 1 bit each: the architectural flags register.
REQ-013 The block SHALL have port jump_cond, input, 3 bits: the jump condition code (present only with JUMP_EVAL_EN).
REQ-014 The block SHALL have port jump_taken, output, 1 bit: the condition evaluated on the head entry (present only with JUMP_EVAL_EN).

Function
REQ-015 The block SHALL be a 2-entry skid buffer with states EMPTY, ONE and TWO, each entry holding {result, C, Z, N}.
REQ-016 A push SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-017 in_ready SHALL be a registered output equal to (next state != TWO).
REQ-018 out_valid SHALL be 1 exactly in states ONE and TWO.
REQ-019 An entry pushed in cycle N SHALL appear on out_* in cycle N+1 when the buffer was empty, giving a latency of 1.
REQ-020 State transitions SHALL be:
- EMPTY with a push goes to ONE.
- ONE with a push and no pop goes to TWO.
- ONE with a pop and no push goes to EMPTY.
- ONE with both a push and a pop stays in ONE, and the new entry becomes the head.
- TWO with a pop goes to ONE, and the second entry becomes the head.
- Any other case holds the current state.
REQ-021 In state TWO no push SHALL be possible, and an in_valid presented in that state SHALL be ignored with no data loss upstream.
REQ-022 Order SHALL be strictly FIFO, and an entry SHALL never be dropped or duplicated.
REQ-023 While out_valid is 1 and out_ready is 0, out_data and out_* flags SHALL hold stable.
REQ-024 On each pop, flag_c, flag_z and flag_n SHALL load the popped entry's flags in the same clock edge; otherwise they SHALL hold.
REQ-025 Data SHALL be stored unmodified at DATA_W bits, with no arithmetic on the data path.

Reset
REQ-026 While reset is high at a rising edge, the state SHALL go to EMPTY and the following outputs SHALL take these values: out_valid 0, in_ready 0, flag_c/flag_z/flag_n 0, out_data 0, out_* flags 0.
REQ-027 In the first cycle after reset deasserts, in_ready SHALL become 1.
REQ-028 A reset asserted mid-operation SHALL discard all buffered entries, and no pop or flag update SHALL occur in that cycle.

Configuration
REQ-029 The macro ALU_STAGE_JUMP_EVAL_EN, when defined, SHALL include the jump_cond and jump_taken ports and the jump evaluation logic.
REQ-030 jump_taken SHALL be combinational: 0 when out_valid is 0, otherwise one of the following by jump_cond:
- 0: always.
- 1: C.
- 2: Z.
- 3: N.
- 4: !C.
- 5: !Z.
- 6: !N.
- 7: never.
These conditions SHALL use the head entry's out_* flags.
REQ-031 Without ALU_STAGE_JUMP_EVAL_EN, the jump ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package alu_stage_pkg SHALL hold the state enum (EMPTY, ONE, TWO), the jump condition code constants (JC_ALWAYS through JC_NEVER) and the entry struct typedef.
REQ-033 The jump evaluation SHALL be the sub-module jump_cond_eval, instantiated only under ALU_STAGE_JUMP_EVAL_EN, and the buffer logic SHALL remain in the top module.

Verification
REQ-034 Single entry: push 0x3C with C=1, Z=0, N=0 while out_ready=1. Required response: out_valid=1 with out_data=0x3C next cycle; at the pop edge flag_c becomes 1.
REQ-035 Fill: hold out_ready=0 and push 0x01, 0x02, then offer 0x03. Required response: in_ready=0 after the second push; releasing out_ready delivers 0x01, 0x02, 0x03 in order with no loss.
REQ-036 Simultaneous push and pop in ONE: head 0x10, push 0x20 with out_ready=1. Required response: the state stays ONE and out_data=0x20 next cycle.
REQ-037 Reset mid-operation: in state TWO, assert reset for 1 cycle. Required response: out_valid=0 and flags 000; in_ready=1 one cycle after release.
REQ-038 Jump evaluation (with the macro): head Z=1, jump_cond=2 gives jump_taken=1; jump_cond=5 gives 0; with out_valid=0 and jump_cond=0, jump_taken=0.
REQ-039 Hold stability: apply random out_ready stalls for 1000 cycles. Required response: out_* remains stable while stalled, and the scoreboard matches in order.
